// File: rtl/mac_sat_seq_pkg.sv
// Shared widths and per-beat operation encodings for the saturating MAC datapath.
package mac_sat_seq_pkg;

  localparam int NUM_WIDTH  = 16;
  localparam int FRAC_WIDTH = 12;

  typedef enum logic [1:0] {
    MAC_OP_MAC  = 2'b00,
    MAC_OP_MSC  = 2'b01,
    MAC_OP_LOAD = 2'b10,
    MAC_OP_BIAS = 2'b11
  } mac_op_e;

endpackage

// File: rtl/mac_sat_seq_narrow.sv
// Combinational signed narrowing from IN_W to WIDTH bits, clamping to the
// representable range and flagging when the clamp was applied.
module sat_narrow #(
  parameter int IN_W  = 33,
  parameter int WIDTH = 16
) (
  input  logic signed [IN_W-1:0]  din,
  output logic signed [WIDTH-1:0] dout,
  output logic                    sat
);

  localparam logic signed [IN_W-1:0] MAX_W = {{(IN_W-WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
  localparam logic signed [IN_W-1:0] MIN_W = {{(IN_W-WIDTH+1){1'b1}}, {(WIDTH-1){1'b0}}};

  always_comb begin
    dout = din[WIDTH-1:0];
    sat  = 1'b0;
    if (din > MAX_W) begin
      dout = {1'b0, {(WIDTH-1){1'b1}}};
      sat  = 1'b1;
    end else if (din < MIN_W) begin
      dout = {1'b1, {(WIDTH-1){1'b0}}};
      sat  = 1'b1;
    end
  end

endmodule

// File: rtl/mac_sat_seq.sv
// Pipelined saturating multiply-accumulate: operand capture, saturated product,
// per-beat saturated accumulate with one held result per vector.
module mac_sat_seq
  import mac_sat_seq_pkg::*;
#(
  parameter int WIDTH = NUM_WIDTH,
  parameter int FRAC  = FRAC_WIDTH
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic signed [WIDTH-1:0] in_a,
  input  logic signed [WIDTH-1:0] in_b,
  input  logic [1:0]              in_op,
  input  logic                    in_last,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [WIDTH-1:0] out_val,
  output logic                    out_sat
);

  localparam int PW = 2 * WIDTH;
  localparam int AW = WIDTH + 1;

  function automatic logic signed [PW-1:0] shr_floor(input logic signed [PW-1:0] x);
    return x >>> FRAC;
  endfunction

  logic stall;
  logic adv;

  assign stall    = out_valid & ~out_ready;
  assign adv      = ~stall;
  assign in_ready = adv;

  // Stage 0: operand capture
  logic                    vld_p0;
  logic signed [WIDTH-1:0] a_p0;
  logic signed [WIDTH-1:0] b_p0;
  mac_op_e                 op_p0;
  logic                    last_p0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)   vld_p0 <= 1'b0;
    else if (adv) vld_p0 <= in_valid;
  end

  always_ff @(posedge clk) begin
    if (adv && in_valid) begin
      a_p0    <= in_a;
      b_p0    <= in_b;
      op_p0   <= mac_op_e'(in_op);
      last_p0 <= in_last;
    end
  end

  // Stage 1: floor-scaled, saturated product
  logic signed [PW-1:0]    prod_full;
  logic signed [PW-1:0]    prod_shr;
  logic signed [WIDTH-1:0] prod_nar;
  logic                    prod_ovf;

  assign prod_full = PW'(a_p0) * PW'(b_p0);
  assign prod_shr  = shr_floor(prod_full);

  sat_narrow #(.IN_W(PW), .WIDTH(WIDTH)) u_prod_narrow (
    .din  (prod_shr),
    .dout (prod_nar),
    .sat  (prod_ovf)
  );

  logic                    vld_p1;
  logic signed [WIDTH-1:0] p_p1;
  logic                    p_sat_p1;
  mac_op_e                 op_p1;
  logic                    last_p1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)   vld_p1 <= 1'b0;
    else if (adv) vld_p1 <= vld_p0;
  end

  always_ff @(posedge clk) begin
    if (adv && vld_p0) begin
      p_p1     <= (op_p0 == MAC_OP_BIAS) ? a_p0 : prod_nar;
      p_sat_p1 <= (op_p0 != MAC_OP_BIAS) && prod_ovf;
      op_p1    <= op_p0;
      last_p1  <= last_p0;
    end
  end

  // Stage 2: accumulate, sticky flag, output register
  logic signed [WIDTH-1:0] acc;
  logic                    first;
  logic                    sat_acc;
  logic signed [WIDTH-1:0] base;
  logic signed [AW-1:0]    base_x;
  logic signed [AW-1:0]    p_x;
  logic signed [AW-1:0]    sum_x;
  logic signed [WIDTH-1:0] acc_nxt;
  logic                    acc_ovf;
  logic                    sat_nxt;

  always_comb begin
    base   = first ? '0 : acc;
    base_x = {base[WIDTH-1], base};
    p_x    = {p_p1[WIDTH-1], p_p1};
    case (op_p1)
      MAC_OP_MSC:  sum_x = base_x - p_x;
      MAC_OP_LOAD: sum_x = p_x;
      default:     sum_x = base_x + p_x;
    endcase
  end

  sat_narrow #(.IN_W(AW), .WIDTH(WIDTH)) u_acc_narrow (
    .din  (sum_x),
    .dout (acc_nxt),
    .sat  (acc_ovf)
  );

  // The sticky flag restarts with each vector, so ignore its old value on a first beat.
  assign sat_nxt = (~first & sat_acc) | p_sat_p1 | acc_ovf;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc       <= '0;
      first     <= 1'b1;
      sat_acc   <= 1'b0;
      out_valid <= 1'b0;
      out_val   <= '0;
      out_sat   <= 1'b0;
    end else begin
      if (adv && vld_p1) begin
        acc     <= acc_nxt;
        sat_acc <= sat_nxt;
        first   <= last_p1;
      end
      if (adv && vld_p1 && last_p1) begin
        out_valid <= 1'b1;
        out_val   <= acc_nxt;
        out_sat   <= sat_nxt;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mac_sat_seq.sv
// Scoreboard bench for mac_sat_seq: directed vectors, backpressure, reset, random traffic.
module tb_mac_sat_seq;

  localparam int W = 16;
  localparam int F = 12;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] in_a = '0;
  logic [W-1:0] in_b = '0;
  logic [1:0]   in_op = 2'b00;
  logic         in_last = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [W-1:0] out_val;
  logic         out_sat;

  always #5 clk = ~clk;

  mac_sat_seq #(.WIDTH(W), .FRAC(F)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_op     (in_op),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_val   (out_val),
    .out_sat   (out_sat)
  );

  typedef struct packed {
    logic [W-1:0] val;
    logic         sat;
  } exp_t;

  exp_t   exp_q[$];
  int     checks = 0;
  int     errors = 0;
  int     rdy_mode = 1;
  bit     directed = 1'b1;
  longint m_acc = 0;
  bit     m_sat = 1'b0;
  bit     m_first = 1'b1;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %h exp %h", name, got, want);
    end
  endtask

  function automatic longint clamp(input longint v, output bit s);
    longint mx = (64'sd1 <<< (W - 1)) - 1;
    longint mn = -(64'sd1 <<< (W - 1));
    s = 1'b0;
    if (v > mx) begin s = 1'b1; return mx; end
    if (v < mn) begin s = 1'b1; return mn; end
    return v;
  endfunction

  // Reference: plain integer arithmetic, floor division by 2^F, clamp each step.
  task automatic model_beat(input logic [W-1:0] a, input logic [W-1:0] b,
                            input logic [1:0] op, input logic last);
    longint sa = longint'($signed(a));
    longint sb = longint'($signed(b));
    longint prod, q, p, r;
    bit ps, os;
    exp_t e;
    if (m_first) begin m_acc = 0; m_sat = 1'b0; end
    if (op == 2'b11) begin
      p = sa; ps = 1'b0;
    end else begin
      prod = sa * sb;
      q = prod / (64'sd1 <<< F);
      if (prod < 0 && (prod % (64'sd1 <<< F)) != 0) q = q - 1;
      p = clamp(q, ps);
    end
    case (op)
      2'b00:   r = m_acc + p;
      2'b01:   r = m_acc - p;
      2'b10:   r = p;
      default: r = m_acc + p;
    endcase
    m_acc = clamp(r, os);
    m_sat = m_sat | ps | os;
    m_first = last;
    if (last && !directed) begin
      e.val = W'(m_acc);
      e.sat = m_sat;
      exp_q.push_back(e);
    end
  endtask

  task automatic push_exp(input logic [W-1:0] v, input logic s);
    exp_t e;
    e.val = v;
    e.sat = s;
    exp_q.push_back(e);
  endtask

  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b,
                      input logic [1:0] op, input logic last);
    int waitc = 0;
    @(negedge clk);
    in_a = a; in_b = b; in_op = op; in_last = last; in_valid = 1'b1;
    while (!in_ready) begin
      @(negedge clk);
      waitc++;
      if (waitc > 200) begin
        errors++;
        $display("FAIL send_timeout got %0d cycles exp <=200", waitc);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1, "input stalled");
      end
    end
    @(posedge clk);
    model_beat(a, b, op, last);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      in_valid = 1'b0;
    end
  endtask

  task automatic drain();
    int c = 0;
    rdy_mode = 1;
    while ((exp_q.size() != 0 || out_valid) && c < 300) begin
      idle(1);
      c++;
    end
    check("drain_left", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    forever begin
      @(posedge clk);
      #2;
      case (rdy_mode)
        0:       out_ready = 1'b0;
        1:       out_ready = 1'b1;
        default: out_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // Monitor: handshake consistency, output hold during stall, scoreboard pops.
  bit           hold_prev = 1'b0;
  logic [W-1:0] prev_val;
  logic         prev_sat;
  exp_t         mon_e;

  always @(negedge clk) begin
    if (!rst_n) begin
      hold_prev = 1'b0;
    end else begin
      check("in_ready", 32'(in_ready), 32'(!(out_valid && !out_ready)));
      if (hold_prev) begin
        check("hold_valid", 32'(out_valid), 32'd1);
        check("hold_val", 32'({out_val, out_sat}), 32'({prev_val, prev_sat}));
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_out", 32'(out_val), 32'hFFFF_FFFF);
        end else begin
          mon_e = exp_q.pop_front();
          check("out_val", 32'(out_val), 32'(mon_e.val));
          check("out_sat", 32'(out_sat), 32'(mon_e.sat));
        end
      end
      hold_prev = out_valid && !out_ready;
      prev_val  = out_val;
      prev_sat  = out_sat;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog got timeout exp finish");
    $display("CHECKS %0d ERRORS %0d", checks + 1, errors + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0] ra, rb;
    logic [1:0]   rop;
    logic         rl;
    int           c;

    repeat (3) @(negedge clk);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_val", 32'(out_val), 32'd0);
    check("rst_out_sat", 32'(out_sat), 32'd0);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("rst_in_ready", 32'(in_ready), 32'd1);

    // Basic MAC and latency
    push_exp(16'h6000, 1'b0);
    send(16'h2000, 16'h3000, 2'b00, 1'b1);
    idle(1);
    idle(1);
    check("lat_edge1", 32'(out_valid), 32'd0);
    idle(1);
    check("lat_edge2", 32'(out_valid), 32'd1);

    // Accumulate overflow, then sticky cleared by next vector
    push_exp(16'h7FFF, 1'b1);
    send(16'h2000, 16'h3000, 2'b00, 1'b0);
    send(16'h2000, 16'h3000, 2'b00, 1'b1);
    push_exp(16'h1000, 1'b0);
    send(16'h1000, 16'h1000, 2'b10, 1'b1);

    // Bias saturates mid-vector, then MSC reduces
    push_exp(16'h3FFF, 1'b1);
    send(16'h4000, 16'h5A5A, 2'b11, 1'b0);
    send(16'h4000, 16'h1234, 2'b11, 1'b0);
    send(16'h4000, 16'h1000, 2'b01, 1'b1);

    // Floor rounding and product saturation
    push_exp(16'h0000, 1'b0);
    send(16'h0001, 16'h0001, 2'b00, 1'b1);
    push_exp(16'hFFFF, 1'b0);
    send(16'hFFFF, 16'h0001, 2'b00, 1'b1);
    push_exp(16'h7FFF, 1'b1);
    send(16'h8000, 16'h8000, 2'b00, 1'b1);
    drain();

    // Backpressure with two single-beat vectors
    rdy_mode = 0;
    idle(2);
    push_exp(16'h2000, 1'b0);
    send(16'h1000, 16'h2000, 2'b00, 1'b1);
    push_exp(16'hF000, 1'b0);
    send(16'hF000, 16'h1000, 2'b10, 1'b1);
    c = 0;
    while (!out_valid && c < 10) begin idle(1); c++; end
    check("bp_valid", 32'(out_valid), 32'd1);
    check("bp_in_ready", 32'(in_ready), 32'd0);
    idle(4);
    check("bp_first_held", 32'(out_val), 32'h2000);
    drain();
    check("bp_done_valid", 32'(out_valid), 32'd0);

    // Reset mid-vector with a pending output
    rdy_mode = 0;
    idle(2);
    send(16'h1000, 16'h1000, 2'b00, 1'b1);
    send(16'h2000, 16'h2000, 2'b00, 1'b0);
    idle(4);
    check("rst_pending", 32'(out_valid), 32'd1);
    #1 rst_n = 1'b0;
    #1;
    check("arst_out_valid", 32'(out_valid), 32'd0);
    check("arst_out_val", 32'(out_val), 32'd0);
    check("arst_out_sat", 32'(out_sat), 32'd0);
    check("arst_in_ready", 32'(in_ready), 32'd1);
    m_first = 1'b1;
    exp_q.delete();
    @(negedge clk);
    #1 rst_n = 1'b1;
    rdy_mode = 1;
    push_exp(16'h1000, 1'b0);
    send(16'h1000, 16'h1000, 2'b00, 1'b1);
    drain();

    // Randomized traffic against the reference model
    directed = 1'b0;
    rdy_mode = 2;
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 4) == 0) idle($urandom_range(1, 2));
      if ($urandom_range(0, 1) == 0) begin
        ra = W'($urandom);
        rb = W'($urandom);
      end else begin
        ra = W'($urandom_range(0, 16'h2000)) - 16'h1000;
        rb = W'($urandom_range(0, 16'h2000)) - 16'h1000;
      end
      rop = 2'($urandom_range(0, 3));
      rl  = (i == 299) || ($urandom_range(0, 3) == 0);
      send(ra, rb, rop, rl);
    end
    idle(1);
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
